// File: rtl/seg7_scan_pkg.sv
// seg7_scan_pkg - shared constants and types for the four-digit seven-segment
// scanner.
//   state_e    : scanner FSM encoding (GAP = all digits dark, DRIVE = one digit lit)
//   SEG_TABLE  : BCD value -> {g,f,e,d,c,b,a}, active-low; 10..15 are dark
//   LED_BLANK  : all segments and dp off
//   SA_OFF     : all anodes off
//   sa_sel()   : active-low one-cold anode pattern for a digit index
package seg7_scan_pkg;

    // The DRIVE length can be as large as 2^20-1 cycles.
    localparam int CNT_W = 20;

    typedef enum logic {
        ST_GAP   = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    localparam logic [7:0] LED_BLANK = 8'hFF;
    localparam logic [3:0] SA_OFF    = 4'hF;

    // Index 0 is the first element. Segment order is {g,f,e,d,c,b,a}, 0 = lit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    function automatic logic [3:0] sa_sel(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if - bundle between a digit source and the display scanner.
//   dig0..dig3 : BCD digit values (dig0 rightmost), source -> scanner
//   dp         : per-digit decimal point, bit n for digit n, 1 = lit
//   led7seg    : {dp,g,f,e,d,c,b,a} active-low, scanner -> display
//   sa         : active-low anode selects, bit n = digit n
//   dbg_state  : current scanner FSM state (observation only)
//   dbg_idx    : current digit index (observation only)
// Handshake: there is no valid/ready pair. The source holds level values; the
// scanner samples all of them together once per frame, on the edge that starts
// driving digit 0, and ignores them at every other edge.
interface seg7_scan_if;
    import seg7_scan_pkg::*;

    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] dp;
    logic [7:0] led7seg;
    logic [3:0] sa;
    state_e     dbg_state;
    logic [1:0] dbg_idx;

    modport master (
        output dig0, dig1, dig2, dig3, dp,
        input  led7seg, sa, dbg_state, dbg_idx
    );

    modport slave (
        input  dig0, dig1, dig2, dig3, dp,
        output led7seg, sa, dbg_state, dbg_idx
    );

endinterface

// File: rtl/seg7_scan_decode.sv
// seg7_decode - combinational BCD-to-seven-segment decoder.
//   value   : 4-bit digit value (10..15 decode to all segments dark)
//   dp      : decimal point request, 1 = lit
//   pattern : {dp,g,f,e,d,c,b,a}, active-low
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] value,
    input  logic       dp,
    output logic [7:0] pattern
);

    assign pattern = {~dp, SEG_TABLE[value]};

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan - time-multiplexed driver for a four-digit common-anode display.
// Each digit is lit for SCAN_MAX cycles, separated by GAP_MAX dark cycles, so a
// frame lasts 4*(SCAN_MAX+GAP_MAX) cycles. All digit values and decimal points
// are snapshotted together at the start of digit 0 so a frame never tears.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : seg7_scan_if.slave (digits/dp in, led7seg/sa out, debug state)
// Optional build macro SEG7_LEADZERO_BLANK_EN: digit 3 with value 0 shows no
// segments (its decimal point still follows dp[3]).
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int unsigned SCAN_MAX = 50000,
    parameter int unsigned GAP_MAX  = 4
) (
    input  logic        clk,
    input  logic        reset,
    seg7_scan_if.slave  bus
);

    state_e          state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [1:0]      idx_q, idx_n;
    logic [3:0][3:0] snap_q, snap_n;
    logic [3:0]      snap_dp_q, snap_dp_n;
    logic [7:0]      led_q, led_n;
    logic [3:0]      sa_q, sa_n;

    logic [3:0]      dec_val;
    logic            dec_dp;
    logic [7:0]      dec_pat;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_GAP;
            cnt_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            snap_dp_q <= '0;
            led_q     <= LED_BLANK;
            sa_q      <= SA_OFF;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            snap_q    <= snap_n;
            snap_dp_q <= snap_dp_n;
            led_q     <= led_n;
            sa_q      <= sa_n;
        end
    end

    // Next state, counter, index and snapshot.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q + CNT_W'(1);
        idx_n     = idx_q;
        snap_n    = snap_q;
        snap_dp_n = snap_dp_q;
        case (state_q)
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_MAX - 1)) begin
                    state_n = ST_DRIVE;
                    cnt_n   = '0;
                    if (idx_q == 2'd0) begin
                        snap_n    = {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
                        snap_dp_n = bus.dp;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == CNT_W'(SCAN_MAX - 1)) begin
                    state_n = ST_GAP;
                    cnt_n   = '0;
                    idx_n   = idx_q + 2'd1;
                end
            end
            default: begin
                state_n = ST_GAP;
                cnt_n   = '0;
            end
        endcase
    end

    // Decode what the next cycle shows, so the registered outputs switch on
    // exactly the edge where state/index switch.
    assign dec_val = snap_n[idx_n];
    assign dec_dp  = snap_dp_n[idx_n];

    seg7_decode u_decode (
        .value   (dec_val),
        .dp      (dec_dp),
        .pattern (dec_pat)
    );

    always_comb begin
        led_n = LED_BLANK;
        sa_n  = SA_OFF;
        if (state_n == ST_DRIVE) begin
            sa_n  = sa_sel(idx_n);
            led_n = dec_pat;
`ifdef SEG7_LEADZERO_BLANK_EN
            if (idx_n == 2'd3 && dec_val == 4'd0) begin
                led_n = {dec_pat[7], 7'h7F};
            end
`else
            // Leading zero on digit 3 is displayed like any other digit.
`endif
        end
    end

    assign bus.led7seg   = led_q;
    assign bus.sa        = sa_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_idx   = idx_q;

endmodule
